// File: rtl/neureka_double_infeat_buffer_ctrl_pkg.sv
// rtl/neureka_double_infeat_buffer_ctrl_pkg.sv - shared types and sizes for the double input-feature buffer controller
package neureka_double_infeat_buffer_ctrl_pkg;

    localparam int NEUREKA_BLOCK_SIZE = 8;
    localparam int DIB_INPUT_BUF_SIZE = 2048;
    localparam int DIB_NW             = DIB_INPUT_BUF_SIZE / NEUREKA_BLOCK_SIZE;
    localparam int DIB_AW             = $clog2(DIB_NW);

    typedef enum logic [1:0] {
        DIB_EMPTY = 2'd0,
        DIB_FILL  = 2'd1,
        DIB_FULL  = 2'd2
    } dib_bank_state_e;

    typedef struct packed {
        logic              wr_start;
        logic [DIB_AW:0]   wr_len;
        logic              rd_done;
    } ctrl_dib_ctrl_t;

    typedef struct packed {
        logic              write;
        logic              read;
        logic              wr_ready;
        logic              rd_valid;
        logic [DIB_AW:0]   rd_len;
        logic [1:0][1:0]   bank_state;
    } flags_dib_ctrl_t;

endpackage

// File: rtl/neureka_double_infeat_buffer_ctrl_if.sv
// rtl/neureka_double_infeat_buffer_ctrl_if.sv - producer/consumer request and status bundle for the buffer controller
interface neureka_double_infeat_buffer_ctrl_if
    import neureka_double_infeat_buffer_ctrl_pkg::*;
#(
    parameter int AW    = DIB_AW,
    parameter int CNT_W = 32
);
    logic             enable_i;
    logic             clear_i;
    logic             wr_start_i;
    logic [AW:0]      wr_len_i;
    logic             wr_hs_i;
    logic             rd_req_i;
    logic             rd_done_i;
    logic             write_o;
    logic             read_o;
    logic             wr_ready_o;
    logic             rd_valid_o;
    logic [AW:0]      rd_len_o;
    logic [1:0][1:0]  bank_state_o;
    logic             wr_err_o;
    logic             rd_err_o;
    logic [CNT_W-1:0] rd_stall_cnt_o;
    logic [CNT_W-1:0] wr_stall_cnt_o;

    modport master (
        output enable_i, clear_i, wr_start_i, wr_len_i, wr_hs_i, rd_req_i, rd_done_i,
        input  write_o, read_o, wr_ready_o, rd_valid_o, rd_len_o, bank_state_o,
               wr_err_o, rd_err_o, rd_stall_cnt_o, wr_stall_cnt_o
    );

    modport slave (
        input  enable_i, clear_i, wr_start_i, wr_len_i, wr_hs_i, rd_req_i, rd_done_i,
        output write_o, read_o, wr_ready_o, rd_valid_o, rd_len_o, bank_state_o,
               wr_err_o, rd_err_o, rd_stall_cnt_o, wr_stall_cnt_o
    );

endinterface

// File: rtl/neureka_double_infeat_buffer_ctrl_bank_fsm.sv
// rtl/neureka_double_infeat_buffer_ctrl_bank_fsm.sv - per-bank occupancy FSM holding tile length and beat count
module neureka_double_infeat_buffer_ctrl_bank_fsm
    import neureka_double_infeat_buffer_ctrl_pkg::*;
#(
    parameter int AW = DIB_AW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            sel_wr,
    input  logic            sel_rd,
    input  logic            start,
    input  logic [AW:0]     len,
    input  logic            hs,
    input  logic            done,
    output dib_bank_state_e state,
    output logic [AW:0]     len_q,
    output logic            last
);
    dib_bank_state_e state_q, state_d;
    logic [AW:0]     len_d;
    logic [AW:0]     cnt_q, cnt_d;

    // High while the next accepted beat closes the tile.
    assign last  = (state_q == DIB_FILL) && (cnt_q == len_q - (AW+1)'(1));
    assign state = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= DIB_EMPTY;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            DIB_EMPTY: begin
                if (sel_wr && start) begin
                    state_d = DIB_FILL;
                    len_d   = len;
                    cnt_d   = '0;
                end
            end
            DIB_FILL: begin
                if (sel_wr && hs) begin
                    if (last) begin
                        state_d = DIB_FULL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + (AW+1)'(1);
                    end
                end
            end
            DIB_FULL: begin
                if (sel_rd && done) begin
                    state_d = DIB_EMPTY;
                end
            end
            default: state_d = DIB_EMPTY;
        endcase
    end

endmodule

// File: rtl/neureka_double_infeat_buffer_ctrl.sv
// rtl/neureka_double_infeat_buffer_ctrl.sv - ping-pong bank select controller; NEUREKA_DIB_CTRL_PERF_EN adds stall counters
module neureka_double_infeat_buffer_ctrl
    import neureka_double_infeat_buffer_ctrl_pkg::*;
#(
    parameter int INPUT_BUF_SIZE = DIB_INPUT_BUF_SIZE,
    parameter int BLOCK_SIZE     = NEUREKA_BLOCK_SIZE,
    parameter int CNT_W          = 32
) (
    input logic                              clk_i,
    input logic                              rst_i,
    neureka_double_infeat_buffer_ctrl_if.slave dib
);
    localparam int NW = INPUT_BUF_SIZE / BLOCK_SIZE;
    localparam int AW = $clog2(NW);

    logic            soft_rst;
    logic            write_q, read_q;
    logic            wr_err_q, rd_err_q;
    dib_bank_state_e bank_state [2];
    logic [AW:0]     bank_len   [2];
    logic [1:0]      bank_last;
    dib_bank_state_e wr_state, rd_state;
    logic            wr_ready, rd_valid, len_ok, hs_req;
    logic            start_ok, start_err, hs_ok, hs_err, done_ok, done_err, wr_toggle;
    ctrl_dib_ctrl_t  ctrl;
    flags_dib_ctrl_t flags;

    assign soft_rst = rst_i | dib.clear_i;

    // Requests are masked here so a disabled cycle can neither move state nor flag errors.
    assign ctrl.wr_start = dib.enable_i & dib.wr_start_i;
    assign ctrl.wr_len   = dib.wr_len_i;
    assign ctrl.rd_done  = dib.enable_i & dib.rd_done_i;
    assign hs_req        = dib.enable_i & dib.wr_hs_i;

    assign wr_state  = bank_state[write_q];
    assign rd_state  = bank_state[read_q];
    assign wr_ready  = dib.enable_i && (wr_state == DIB_EMPTY);
    assign rd_valid  = (rd_state == DIB_FULL);
    assign len_ok    = (ctrl.wr_len != '0) && (ctrl.wr_len <= (AW+1)'(NW));

    assign start_ok  = ctrl.wr_start && wr_ready && len_ok;
    assign start_err = ctrl.wr_start && !(wr_ready && len_ok);
    assign hs_ok     = hs_req && (wr_state == DIB_FILL);
    assign hs_err    = hs_req && (wr_state != DIB_FILL);
    assign done_ok   = ctrl.rd_done && rd_valid;
    assign done_err  = ctrl.rd_done && !rd_valid;
    assign wr_toggle = hs_ok && bank_last[write_q];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        neureka_double_infeat_buffer_ctrl_bank_fsm #(.AW(AW)) u_bank (
            .clk_i  (clk_i),
            .rst_i  (soft_rst),
            .sel_wr (write_q == 1'(b)),
            .sel_rd (read_q == 1'(b)),
            .start  (start_ok),
            .len    (ctrl.wr_len),
            .hs     (hs_ok),
            .done   (done_ok),
            .state  (bank_state[b]),
            .len_q  (bank_len[b]),
            .last   (bank_last[b])
        );
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            write_q  <= 1'b0;
            read_q   <= 1'b0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            write_q  <= write_q ^ wr_toggle;
            read_q   <= read_q ^ done_ok;
            wr_err_q <= start_err | hs_err;
            rd_err_q <= done_err;
        end
    end

    assign flags.write      = write_q;
    assign flags.read       = read_q;
    assign flags.wr_ready   = wr_ready;
    assign flags.rd_valid   = rd_valid;
    assign flags.rd_len     = bank_len[read_q];
    assign flags.bank_state = {bank_state[1], bank_state[0]};

    assign dib.write_o      = flags.write;
    assign dib.read_o       = flags.read;
    assign dib.wr_ready_o   = flags.wr_ready;
    assign dib.rd_valid_o   = flags.rd_valid;
    assign dib.rd_len_o     = flags.rd_len;
    assign dib.bank_state_o = flags.bank_state;
    assign dib.wr_err_o     = wr_err_q;
    assign dib.rd_err_o     = rd_err_q;

`ifdef NEUREKA_DIB_CTRL_PERF_EN
    logic [CNT_W-1:0] rd_stall_q, wr_stall_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            rd_stall_q <= '0;
            wr_stall_q <= '0;
        end else begin
            if (dib.enable_i && dib.rd_req_i && !rd_valid && !(&rd_stall_q))
                rd_stall_q <= rd_stall_q + CNT_W'(1);
            if (dib.enable_i && (wr_state == DIB_FULL) && !(&wr_stall_q))
                wr_stall_q <= wr_stall_q + CNT_W'(1);
        end
    end

    assign dib.rd_stall_cnt_o = rd_stall_q;
    assign dib.wr_stall_cnt_o = wr_stall_q;
`else
    logic perf_unused;
    assign perf_unused        = dib.rd_req_i;
    assign dib.rd_stall_cnt_o = '0;
    assign dib.wr_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_neureka_double_infeat_buffer_ctrl.sv
// tb/tb_neureka_double_infeat_buffer_ctrl.sv - scoreboard bench for the double input-feature buffer controller
module tb_neureka_double_infeat_buffer_ctrl;
    import neureka_double_infeat_buffer_ctrl_pkg::*;

    localparam int AW = DIB_AW;
    localparam int E  = 0;
    localparam int F  = 1;
    localparam int U  = 2;
`ifdef NEUREKA_DIB_CTRL_PERF_EN
    localparam int EXP_RD_STALL = 5;
`else
    localparam int EXP_RD_STALL = 0;
`endif

    typedef struct {
        int          tag;
        logic [18:0] vec;
        bit          chk_cnt;
        logic [31:0] rd_stall;
        logic [31:0] wr_stall;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neureka_double_infeat_buffer_ctrl_if #(.AW(AW), .CNT_W(32)) dib ();

    neureka_double_infeat_buffer_ctrl #(.CNT_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .dib   (dib)
    );

    function automatic logic [18:0] pk(int w, int r, int rdy, int v, int len,
                                       int bs1, int bs0, int we, int re);
        return {1'(w), 1'(r), 1'(rdy), 1'(v), 9'(len), 2'(bs1), 2'(bs0), 1'(we), 1'(re)};
    endfunction

    task automatic push(string name, logic [18:0] vec, bit chk_cnt, int rs, int ws, int tag);
        exp_t e;
        e.tag      = tag;
        e.vec      = vec;
        e.chk_cnt  = chk_cnt;
        e.rd_stall = 32'(rs);
        e.wr_stall = 32'(ws);
        e.name     = name;
        sb.push_back(e);
    endtask

    task automatic idle();
        dib.enable_i   = 1'b1;
        dib.clear_i    = 1'b0;
        dib.wr_start_i = 1'b0;
        dib.wr_len_i   = '0;
        dib.wr_hs_i    = 1'b0;
        dib.rd_req_i   = 1'b0;
        dib.rd_done_i  = 1'b0;
    endtask

    // One request cycle, then one idle cycle in which the outcome is observed.
    task automatic step(string name, int en, int clr, int st, int len, int hs, int dn,
                        logic [18:0] exp_vec);
        @(posedge clk);
        #1;
        dib.enable_i   = 1'(en);
        dib.clear_i    = 1'(clr);
        dib.wr_start_i = 1'(st);
        dib.wr_len_i   = (AW+1)'(len);
        dib.wr_hs_i    = 1'(hs);
        dib.rd_done_i  = 1'(dn);
        push(name, exp_vec, 1'b0, 0, 0, cyc + 1);
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin : monitor
        exp_t        e;
        logic [18:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].tag <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.tag < cyc) begin
                    errors++;
                    $display("FAIL %s: check missed, due cycle %0d now %0d", e.name, e.tag, cyc);
                    continue;
                end
                act = {dib.write_o, dib.read_o, dib.wr_ready_o, dib.rd_valid_o, dib.rd_len_o,
                       dib.bank_state_o[1], dib.bank_state_o[0], dib.wr_err_o, dib.rd_err_o};
                if (act !== e.vec) begin
                    errors++;
                    $display("FAIL %s: got w/r/rdy/v/len/bs1/bs0/we/re=%b/%b/%b/%b/%0d/%0d/%0d/%b/%b expected %b/%b/%b/%b/%0d/%0d/%0d/%b/%b",
                             e.name, act[18], act[17], act[16], act[15], act[14:6], act[5:4], act[3:2], act[1], act[0],
                             e.vec[18], e.vec[17], e.vec[16], e.vec[15], e.vec[14:6], e.vec[5:4], e.vec[3:2], e.vec[1], e.vec[0]);
                end
                if (e.chk_cnt) begin
                    checks++;
                    if (dib.rd_stall_cnt_o !== e.rd_stall || dib.wr_stall_cnt_o !== e.wr_stall) begin
                        errors++;
                        $display("FAIL %s_cnt: got rd_stall=%0d wr_stall=%0d expected rd_stall=%0d wr_stall=%0d",
                                 e.name, dib.rd_stall_cnt_o, dib.wr_stall_cnt_o, e.rd_stall, e.wr_stall);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        push("reset", pk(0,0,1,0,0,E,E,0,0), 1'b1, 0, 0, cyc);

        step("b0_start4",   1,0,1,4,0,0, pk(0,0,0,0,4,E,F,0,0));
        step("b0_beat1",    1,0,0,0,1,0, pk(0,0,0,0,4,E,F,0,0));
        step("b0_beat2",    1,0,0,0,1,0, pk(0,0,0,0,4,E,F,0,0));
        step("b0_beat3",    1,0,0,0,1,0, pk(0,0,0,0,4,E,F,0,0));
        step("b0_last",     1,0,0,0,1,0, pk(1,0,1,1,4,E,U,0,0));
        step("b1_start2",   1,0,1,2,0,0, pk(1,0,0,1,4,F,U,0,0));
        step("b1_beat1",    1,0,0,0,1,0, pk(1,0,0,1,4,F,U,0,0));
        step("b1_last",     1,0,0,0,1,0, pk(0,0,0,1,4,U,U,0,0));
        step("start_full",  1,0,1,3,0,0, pk(0,0,0,1,4,U,U,1,0));
        step("done_b0",     1,0,0,0,0,1, pk(0,1,1,1,2,U,E,0,0));
        step("done_b1",     1,0,0,0,0,1, pk(0,0,1,0,4,E,E,0,0));

        step("hs_empty",    1,0,0,0,1,0, pk(0,0,1,0,4,E,E,1,0));
        step("len_zero",    1,0,1,0,0,0, pk(0,0,1,0,4,E,E,1,0));
        step("len_nw_p1",   1,0,1,DIB_NW+1,0,0, pk(0,0,1,0,4,E,E,1,0));
        step("done_empty",  1,0,0,0,0,1, pk(0,0,1,0,4,E,E,0,1));
        step("disabled",    0,0,1,4,1,1, pk(0,0,1,0,4,E,E,0,0));
        step("start_w_hs",  1,0,1,2,1,0, pk(0,0,0,0,2,E,F,1,0));
        step("b0_beat1b",   1,0,0,0,1,0, pk(0,0,0,0,2,E,F,0,0));
        step("b0_lastb",    1,0,0,0,1,0, pk(1,0,1,1,2,E,U,0,0));
        step("b1_start2b",  1,0,1,2,0,0, pk(1,0,0,1,2,F,U,0,0));
        step("b1_beat1b",   1,0,0,0,1,0, pk(1,0,0,1,2,F,U,0,0));
        step("last_w_done", 1,0,0,0,1,1, pk(0,1,1,1,2,U,E,0,0));
        step("start_nw",    1,0,1,DIB_NW,0,0, pk(0,1,0,1,2,U,F,0,0));

        step("clear_a",     1,1,0,0,0,0, pk(0,0,1,0,0,E,E,0,0));
        step("c_start4",    1,0,1,4,0,0, pk(0,0,0,0,4,E,F,0,0));
        step("c_beat1",     1,0,0,0,1,0, pk(0,0,0,0,4,E,F,0,0));
        step("c_beat2",     1,0,0,0,1,0, pk(0,0,0,0,4,E,F,0,0));
        step("clear_b",     1,1,0,0,0,0, pk(0,0,1,0,0,E,E,0,0));

        @(posedge clk);
        #1;
        dib.rd_req_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        dib.rd_req_i = 1'b0;
        push("rd_stall", pk(0,0,1,0,0,E,E,0,0), 1'b1, EXP_RD_STALL, 0, cyc);

        repeat (3) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            checks += sb.size();
            errors += sb.size();
            $display("FAIL scoreboard_drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
